// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between fetch and data ports.
// Data wins ties until MAX_D_RUN grants; a watchdog aborts lost accesses.
//
// Ports:
//  clk, rst        clock, async active-low reset
//  if_*            fetch request in, fetch rdata/done out
//  d_*             data request in, data rdata/done out
//  stallreq_o      core stall while a request is pending
//  bus_err_o       pulses with done when the watchdog aborted
//  m_*             registered memory bus, m_ack_i/m_rdata_i back

module mem_bus_arbiter #(
  parameter int MAX_D_RUN   = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_done_o,
  input  logic        d_ce_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_sel_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic [31:0] d_rdata_o,
  output logic        d_done_o,
  output logic        stallreq_o,
  output logic        bus_err_o,
  output logic        m_req_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  input  logic [31:0] m_rdata_i,
  input  logic        m_ack_i
);

  typedef enum logic [1:0] {
    IDLE,
    GNT_IF,
    GNT_D,
    DONE
  } state_t;

  localparam logic [3:0] RUN_MAX = 4'(MAX_D_RUN);
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYC - 1);

  state_t      state;
  state_t      state_d;
  logic [3:0]  d_run;
  logic [7:0]  wdog;
  logic        run_full;
  logic        want_d;
  logic        want_if;
  logic        pick_d;
  logic        pick_if;
  logic        ack;
  logic        tmo;
  logic        fin;

  assign run_full = (d_run == RUN_MAX);
  // Data wins a tie unless it has already had its run.
  assign want_d   = d_ce_i & ~(if_ce_i & run_full);
  assign want_if  = if_ce_i & ~want_d;
  assign fin      = ack | tmo;

  assign stallreq_o = (if_ce_i & ~if_done_o)
                    | (d_ce_i & ~d_done_o);

  always_comb begin
    state_d = state;
    pick_d  = 1'b0;
    pick_if = 1'b0;
    ack     = 1'b0;
    tmo     = 1'b0;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          want_d: begin
            pick_d  = 1'b1;
            state_d = GNT_D;
          end
          want_if: begin
            pick_if = 1'b1;
            state_d = GNT_IF;
          end
          default: ;
        endcase
      end
      GNT_IF, GNT_D: begin
        ack = m_ack_i;
        tmo = ~m_ack_i & (wdog == WD_LAST);
        if (ack || tmo) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata_o <= '0;
      if_done_o  <= 1'b0;
      d_rdata_o  <= '0;
      d_done_o   <= 1'b0;
      bus_err_o  <= 1'b0;
      m_req_o    <= 1'b0;
      m_we_o     <= 1'b0;
      m_sel_o    <= '0;
      m_addr_o   <= '0;
      m_wdata_o  <= '0;
      d_run      <= '0;
      wdog       <= '0;
    end else begin
      if_done_o <= 1'b0;
      d_done_o  <= 1'b0;
      bus_err_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!if_ce_i) d_run <= '0;
          if (pick_d) begin
            m_req_o   <= 1'b1;
            m_we_o    <= d_we_i;
            m_sel_o   <= d_sel_i;
            m_addr_o  <= d_addr_i;
            m_wdata_o <= d_wdata_i;
            wdog      <= '0;
          end else if (pick_if) begin
            m_req_o   <= 1'b1;
            m_we_o    <= 1'b0;
            m_sel_o   <= 4'hF;
            m_addr_o  <= if_addr_i;
            m_wdata_o <= '0;
            wdog      <= '0;
          end
        end
        GNT_IF, GNT_D: begin
          if (fin) begin
            m_req_o   <= 1'b0;
            bus_err_o <= tmo;
            if (state == GNT_D) begin
              d_rdata_o <= ack ? m_rdata_i : '0;
              d_done_o  <= 1'b1;
              if (if_ce_i && !run_full)
                d_run <= d_run + 4'd1;
            end else begin
              if_rdata_o <= ack ? m_rdata_i : '0;
              if_done_o  <= 1'b1;
              d_run      <= '0;
            end
          end else begin
            wdog <= wdog + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
